dlfloat_result_serializer: RTL and testbench
============================================

Name: dlfloat_result_serializer

Overview:
- Downstream stage of the DLFloat16 MAC.
- Captures 16-bit accumulator results on a valid strobe and buffers them in a small FIFO.
- Streams each result out as bytes (low byte first) over an 8-bit valid/ready interface.
- Replaces free-running byte toggling: no byte is lost or duplicated under output back-pressure.

Parameters:
- DEPTH, 4, FIFO depth in 16-bit entries; power of two, >= 2.
- CW, $clog2(DEPTH+1), width of fifo_count.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  reset, asynchronous assert, active-low
- res_in  input  16  DLFloat16 result word {sign, exp[5:0], mant[8:0]} from MAC output register
- res_valid  input  1  res_in valid this cycle; single-cycle push request
- out_byte  output  8  serialized byte, registered
- out_valid  output  1  out_byte valid, registered
- out_ready  input  1  consumer accepts out_byte when out_valid && out_ready at rising edge
- fifo_count  output  CW  entries held in FIFO; excludes word in output register
- overflow  output  1  sticky: a result was dropped because FIFO was full
- clr_ovf  input  1  synchronous clear of overflow

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset: out_byte=0, out_valid=0, fifo_count=0, overflow=0, FSM=IDLE, pointers=0. Outputs clear immediately on rst_n low, including mid-transfer; partially sent words are discarded.
- FIFO push: res_valid && count<DEPTH -> write at wr_ptr, wr_ptr wraps modulo DEPTH.
- Full check uses the registered count. A push while full is dropped and sets overflow next edge, even if a pop occurs that cycle.
- Pop: happens only when the FSM loads the head word into the 16-bit output holding register.
  - Simultaneous push and pop: count unchanged; both pointers advance.
- FSM states:
  - IDLE: out_valid=0. If count>0: load head, pop, out_byte<=head[7:0], out_valid<=1, go LO.
  - LO: hold out_byte/out_valid while !out_ready. On transfer: out_byte<=word[15:8], go HI.
  - HI: hold while !out_ready. On transfer: if count>0, load next head directly into LO (no bubble); else out_valid<=0, go IDLE.
- Latency: res_valid at edge N with FIFO empty and FSM IDLE -> out_valid=1 with low byte after edge N+1; first byte is visible 2 cycles after res_valid is sampled.
- Throughput: one byte per cycle with out_ready held high; a word every 2 cycles.
- Bytes are never reordered. out_byte and out_valid must not change while out_valid && !out_ready.
- overflow: set wins over clr_ovf in the same cycle; otherwise clr_ovf clears it next edge.
- No inspection or modification of the float encoding, except in the optional feature.

Optional Feature:
- Macro: DLF_STATUS_BYTE_EN.
- Defined:
  - Each word is followed by a third byte; HI transfer goes to state ST instead of LO/IDLE.
  - ST emits status={4'b1010, ovf_snap, sign, sat, zero}:
    - zero = (word==16'h0000)
    - sat = (word==16'hFFFF)
    - sign = word[15] && !sat
    - ovf_snap = overflow value at load time
  - ST transfer follows the same next-state rule that HI follows without the feature.
  - Throughput: 3 cycles per word.
- Undefined: two bytes per word, no ST state, no status logic synthesized.

Test Plan:
- Reset, push 16'h3C80, out_ready=1 -> out_byte 8'h80 then 8'h3C on consecutive cycles, then out_valid=0, fifo_count=0.
- Push 16'h1234 and 16'hABCD back-to-back, out_ready=1 -> bytes 34,12,CD,AB with no bubble, fifo_count peaks at 1.
- out_ready=0 for 5 cycles after low byte of 16'h5A5A presented -> out_byte stays 8'h5A, out_valid stays 1; then bytes 5A,5A accepted exactly once.
- out_ready=0, push DEPTH+2 words -> first word in holding register, FIFO full (count=DEPTH), last word dropped, overflow=1. Then out_ready=1 -> exactly DEPTH+1 words out in order. clr_ovf -> overflow=0.
- Assert rst_n=0 mid-word (after low byte of 16'hBEEF) -> out_valid=0 immediately, count=0. After release, no stale 8'hBE is emitted.
- With DLF_STATUS_BYTE_EN: push 16'hFFFF, then 16'h0000 -> bytes FF,FF,A2,00,00,A1.

Source files
------------

// File: rtl/dlfloat_result_serializer.sv
// dlfloat_result_serializer
//   Buffers 16-bit DLFloat16 MAC results in a small FIFO and streams each
//   result out as bytes, low byte first, over an 8-bit valid/ready link.
//   No byte is lost or duplicated under back-pressure.
//
// Ports
//   clk        : system clock, all state on rising edge
//   rst_n      : asynchronous active-low reset
//   res_in     : result word {sign, exp[5:0], mant[8:0]}
//   res_valid  : single-cycle push request for res_in
//   out_byte   : serialized byte (registered)
//   out_valid  : out_byte valid (registered)
//   out_ready  : consumer accepts out_byte when out_valid && out_ready
//   fifo_count : entries held in the FIFO (not counting the word being sent)
//   overflow   : sticky, a result was dropped because the FIFO was full
//   clr_ovf    : synchronous clear of overflow (a new drop wins)
//
// Optional build macro
//   DLF_STATUS_BYTE_EN : append a third status byte to every word,
//                        {4'b1010, ovf_snap, sign, sat, zero}.

module dlfloat_result_serializer #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [15:0]   res_in,
    input  logic          res_valid,
    output logic [7:0]    out_byte,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] fifo_count,
    output logic          overflow,
    input  logic          clr_ovf
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LO   = 2'd1;
    localparam logic [1:0] S_HI   = 2'd2;
`ifdef DLF_STATUS_BYTE_EN
    localparam logic [1:0] S_ST   = 2'd3;
`endif

    logic [15:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [1:0]    state;
    logic [7:0]    hi_byte;
    logic [15:0]   head;
    logic          full;
    logic          has_data;
    logic          push;
    logic          pop;
    logic          word_done;

`ifdef DLF_STATUS_BYTE_EN
    logic [7:0]    status_byte;
    logic          head_zero;
    logic          head_sat;
`endif

    assign head     = mem[rd_ptr];
    assign full     = (count == CW'(DEPTH));
    assign has_data = (count != '0);
    // Full check deliberately uses the registered count: a push that
    // arrives while full is dropped even if a pop frees a slot this cycle.
    assign push     = res_valid && !full;

    // The final byte of a word has been accepted this cycle.
`ifdef DLF_STATUS_BYTE_EN
    assign word_done = out_ready && (state == S_ST);
`else
    assign word_done = out_ready && (state == S_HI);
`endif

    // Loading the head from IDLE or straight after the last byte keeps the
    // stream bubble-free when the FIFO holds more words.
    assign pop = has_data && ((state == S_IDLE) || word_done);

`ifdef DLF_STATUS_BYTE_EN
    assign head_zero = (head == 16'h0000);
    assign head_sat  = (head == 16'hFFFF);
`endif

    // FIFO storage needs no reset; occupancy is tracked by count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= res_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (res_valid && full) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            out_byte  <= '0;
            out_valid <= 1'b0;
            hi_byte   <= '0;
`ifdef DLF_STATUS_BYTE_EN
            status_byte <= '0;
`endif
        end else if (pop) begin
            out_byte  <= head[7:0];
            out_valid <= 1'b1;
            hi_byte   <= head[15:8];
            state     <= S_LO;
`ifdef DLF_STATUS_BYTE_EN
            // Status is derived once at load time so it reflects the word
            // and the overflow flag as they were when the word left the FIFO.
            status_byte <= {4'b1010, overflow, head[15] && !head_sat,
                            head_sat, head_zero};
`endif
        end else if (word_done) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
        end else if (out_ready && (state == S_LO)) begin
            out_byte <= hi_byte;
            state    <= S_HI;
`ifdef DLF_STATUS_BYTE_EN
        end else if (out_ready && (state == S_HI)) begin
            out_byte <= status_byte;
            state    <= S_ST;
`endif
        end
    end

    assign fifo_count = count;

endmodule

// File: tb/tb_dlfloat_result_serializer.sv
module tb_dlfloat_result_serializer;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk;
    logic          rst_n;
    logic [15:0]   res_in;
    logic          res_valid;
    logic [7:0]    out_byte;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] fifo_count;
    logic          overflow;
    logic          clr_ovf;

    int vectors;
    int miscompares;

    dlfloat_result_serializer #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .res_in     (res_in),
        .res_valid  (res_valid),
        .out_byte   (out_byte),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .clr_ovf    (clr_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        res_in      = '0;
        res_valid   = 1'b0;
        out_ready   = 1'b1;
        clr_ovf     = 1'b0;

        // Reset state
        #2;
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_byte", 32'(out_byte), 32'h0);
        check("rst_count", 32'(fifo_count), 32'h0);
        check("rst_overflow", 32'(overflow), 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

`ifndef DLF_STATUS_BYTE_EN
        // Single word 3C80: first byte two cycles after the push is sampled
        res_in = 16'h3C80; res_valid = 1'b1;
        tick();
        res_valid = 1'b0;
        check("w1_count_after_push", 32'(fifo_count), 32'h1);
        check("w1_no_early_valid", 32'(out_valid), 32'h0);
        tick();
        check("w1_lo_valid", 32'(out_valid), 32'h1);
        check("w1_lo_byte", 32'(out_byte), 32'h80);
        check("w1_count_loaded", 32'(fifo_count), 32'h0);
        tick();
        check("w1_hi_valid", 32'(out_valid), 32'h1);
        check("w1_hi_byte", 32'(out_byte), 32'h3C);
        tick();
        check("w1_idle_valid", 32'(out_valid), 32'h0);
        check("w1_idle_count", 32'(fifo_count), 32'h0);

        // Back-to-back 1234, ABCD with no bubble
        res_in = 16'h1234; res_valid = 1'b1;
        tick();
        res_in = 16'hABCD;
        check("b2b_count_a", 32'(fifo_count), 32'h1);
        tick();
        res_valid = 1'b0;
        check("b2b_byte0", 32'(out_byte), 32'h34);
        check("b2b_count_peak", 32'(fifo_count), 32'h1);
        tick();
        check("b2b_byte1", 32'(out_byte), 32'h12);
        tick();
        check("b2b_byte2", 32'(out_byte), 32'hCD);
        check("b2b_valid2", 32'(out_valid), 32'h1);
        check("b2b_count_drained", 32'(fifo_count), 32'h0);
        tick();
        check("b2b_byte3", 32'(out_byte), 32'hAB);
        tick();
        check("b2b_idle", 32'(out_valid), 32'h0);

        // Back-pressure on 5A5A
        res_in = 16'h5A5A; res_valid = 1'b1;
        tick();
        res_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        check("bp_lo_byte", 32'(out_byte), 32'h5A);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold_valid", 32'(out_valid), 32'h1);
            check("bp_hold_byte", 32'(out_byte), 32'h5A);
        end
        out_ready = 1'b1;
        tick();
        check("bp_hi_valid", 32'(out_valid), 32'h1);
        check("bp_hi_byte", 32'(out_byte), 32'h5A);
        tick();
        check("bp_done", 32'(out_valid), 32'h0);

        // Overflow: DEPTH+2 pushes while stalled, 0101..0606
        out_ready = 1'b0;
        for (int k = 1; k <= DEPTH + 2; k++) begin
            res_in = {8'(k), 8'(k)}; res_valid = 1'b1;
            tick();
            if (k == DEPTH + 1) begin
                check("ovf_full_count", 32'(fifo_count), 32'(DEPTH));
                check("ovf_not_yet", 32'(overflow), 32'h0);
            end
        end
        res_valid = 1'b0;
        check("ovf_set", 32'(overflow), 32'h1);
        check("ovf_count_held", 32'(fifo_count), 32'(DEPTH));
        check("ovf_head_valid", 32'(out_valid), 32'h1);
        out_ready = 1'b1;
        for (int i = 0; i < 2 * (DEPTH + 1); i++) begin
            check("ovf_drain_valid", 32'(out_valid), 32'h1);
            check("ovf_drain_byte", 32'(out_byte), 32'(i / 2 + 1));
            tick();
        end
        check("ovf_drain_end", 32'(out_valid), 32'h0);
        check("ovf_drain_count", 32'(fifo_count), 32'h0);
        check("ovf_sticky", 32'(overflow), 32'h1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check("ovf_cleared", 32'(overflow), 32'h0);

        // Reset mid-word after BEEF low byte
        res_in = 16'hBEEF; res_valid = 1'b1;
        tick();
        res_valid = 1'b0;
        tick();
        check("mid_lo_byte", 32'(out_byte), 32'hEF);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'h0);
        check("mid_rst_count", 32'(fifo_count), 32'h0);
        check("mid_rst_byte", 32'(out_byte), 32'h0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("mid_no_stale", 32'(out_valid), 32'h0);
        end
`else
        // Status byte: FFFF then 0000
        res_in = 16'hFFFF; res_valid = 1'b1;
        tick();
        res_in = 16'h0000;
        tick();
        res_valid = 1'b0;
        check("st_b0", 32'(out_byte), 32'hFF);
        tick();
        check("st_b1", 32'(out_byte), 32'hFF);
        tick();
        check("st_b2", 32'(out_byte), 32'hA2);
        check("st_b2_valid", 32'(out_valid), 32'h1);
        tick();
        check("st_b3", 32'(out_byte), 32'h00);
        check("st_b3_valid", 32'(out_valid), 32'h1);
        tick();
        check("st_b4", 32'(out_byte), 32'h00);
        tick();
        check("st_b5", 32'(out_byte), 32'hA1);
        tick();
        check("st_idle", 32'(out_valid), 32'h0);
        check("st_count", 32'(fifo_count), 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
